// File: rtl/stack_sequencer_if.sv
// Bus bundle between the control unit / stack pointer / memory and the stack sequencer.
// "slave" is the sequencer's view; "master" is the view of everything around it.
interface stack_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [15:0] pc_in;
  logic [7:0]  p_in;
  logic [7:0]  data_in;
  logic        rdy;
  logic [7:0]  sp;
  logic [1:0]  sp_sel;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        re;
  logic [7:0]  rdata;
  logic        busy;
  logic        done;
  logic [15:0] pc_out;
  logic [7:0]  p_out;
  logic [7:0]  data_out;
  logic        fault;

  modport master (
    output start, op, pc_in, p_in, data_in, rdy, sp, rdata,
    input  sp_sel, addr, wdata, we, re, busy, done, pc_out, p_out, data_out, fault
  );

  modport slave (
    input  start, op, pc_in, p_in, data_in, rdy, sp, rdata,
    output sp_sel, addr, wdata, we, re, busy, done, pc_out, p_out, data_out, fault
  );
endinterface

// File: rtl/stack_sequencer.sv
// Stack access engine: sequences the 1-3 byte push/pull transfers for PUSH1/PULL1,
// JSR/RTS and INT/RTI on the stack page, steering the external stack pointer.
module stack_sequencer #(
  parameter logic [7:0] STACK_PAGE = 8'h01
) (
  input  logic            clk,
  input  logic            reset,
  stack_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_INC  = 2'b01;
  localparam logic [1:0] SP_DEC  = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  p_q, p_d;
  logic [7:0]  din_q, din_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic [7:0]  p_out_q, p_out_d;
  logic [7:0]  data_out_q, data_out_d;

  logic [1:0]  sp_sel;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        re;
  logic        fault;
  logic        last;
  logic [7:0]  push_byte;

  // op[2:1] encodes byte count minus one; op[0] selects pull
  assign last = (idx_q == op_q[2:1]);

  // Byte to write for the current index, in push order (PCH, PCL, P)
  always_comb begin
    push_byte = din_q;
    unique case (op_q[2:1])
      2'b01:   push_byte = (idx_q == 2'd0) ? pc_q[15:8] : pc_q[7:0];
      2'b10: begin
        unique case (idx_q)
          2'd0:    push_byte = pc_q[15:8];
          2'd1:    push_byte = pc_q[7:0];
          default: push_byte = p_q;
        endcase
      end
      default: push_byte = din_q;
    endcase
  end

  // Next-state, strobes and result capture
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_d       = op_q;
    pc_d       = pc_q;
    p_d        = p_q;
    din_d      = din_q;
    pc_out_d   = pc_out_q;
    p_out_d    = p_out_q;
    data_out_d = data_out_q;
    sp_sel     = SP_HOLD;
    addr       = '0;
    wdata      = '0;
    we         = 1'b0;
    re         = 1'b0;
    fault      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.op[2:1] != 2'b11)) begin
          op_d    = bus.op;
          pc_d    = bus.pc_in;
          p_d     = bus.p_in;
          din_d   = bus.data_in;
          idx_d   = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (bus.rdy) begin
          // sp already reflects the pre-increment on pulls, so one address form serves both
          addr  = {STACK_PAGE, bus.sp};
          fault = (bus.sp == 8'h00);
          if (op_q[0]) begin
            sp_sel = SP_INC;
            re     = 1'b1;
            unique case (op_q[2:1])
              2'b00: data_out_d = bus.rdata;
              2'b01: begin
                if (idx_q == 2'd0) pc_out_d[7:0]  = bus.rdata;
                else               pc_out_d[15:8] = bus.rdata;
              end
              default: begin
                unique case (idx_q)
                  2'd0:    p_out_d         = bus.rdata;
                  2'd1:    pc_out_d[7:0]   = bus.rdata;
                  default: pc_out_d[15:8]  = bus.rdata;
                endcase
              end
            endcase
          end else begin
            sp_sel = SP_DEC;
            we     = 1'b1;
            wdata  = push_byte;
          end
          if (last) state_d = DONE;
          else      idx_d   = idx_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      op_q       <= '0;
      pc_q       <= '0;
      p_q        <= '0;
      din_q      <= '0;
      pc_out_q   <= '0;
      p_out_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      pc_q       <= pc_d;
      p_q        <= p_d;
      din_q      <= din_d;
      pc_out_q   <= pc_out_d;
      p_out_q    <= p_out_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.sp_sel   = sp_sel;
  assign bus.addr     = addr;
  assign bus.wdata    = wdata;
  assign bus.we       = we;
  assign bus.re       = re;
  assign bus.fault    = fault;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.pc_out   = pc_out_q;
  assign bus.p_out    = p_out_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: models the stack pointer register and
// page-1 memory around the DUT, and predicts every cycle from a byte-list model.
module tb_stack_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b0;

  stack_sequencer_if bus();

  stack_sequencer #(.STACK_PAGE(8'h01)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Environment: stack pointer register and stack memory
  logic [7:0] sp_reg;
  logic       sp_ld;
  logic [7:0] sp_ld_val;
  logic       mem_clr;
  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (sp_ld)                    sp_reg <= sp_ld_val;
    else if (bus.sp_sel == 2'b01) sp_reg <= sp_reg + 8'd1;
    else if (bus.sp_sel == 2'b10) sp_reg <= sp_reg - 8'd1;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.we) begin
      mem[bus.addr[7:0]] <= bus.wdata;
    end
  end

  assign bus.sp    = (bus.sp_sel == 2'b01) ? sp_reg + 8'd1 : sp_reg;
  assign bus.rdata = mem[bus.addr[7:0]];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: stack pointer, shadow stack, pulled results
  logic [7:0]  msp;
  logic [7:0]  mmem [256];
  logic [15:0] m_pc;
  logic [7:0]  m_p;
  logic [7:0]  m_data;

  // Per-cycle expectations
  bit          cmp_en;
  logic        e_busy, e_done, e_we, e_re, e_fault;
  logic [1:0]  e_sel;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata;

  // Observations from the last run_op
  logic [15:0] first_addr;
  logic [7:0]  first_wdata;
  logic [1:0]  first_sel;
  int          fault_cnt;
  int          last_lat;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",   32'(bus.busy),   32'(e_busy));
      check("done",   32'(bus.done),   32'(e_done));
      check("we",     32'(bus.we),     32'(e_we));
      check("re",     32'(bus.re),     32'(e_re));
      check("sp_sel", 32'(bus.sp_sel), 32'(e_sel));
      check("fault",  32'(bus.fault),  32'(e_fault));
      if (e_we) begin
        check("waddr", 32'(bus.addr),  32'(e_addr));
        check("wdata", 32'(bus.wdata), 32'(e_wdata));
      end
      if (e_re) check("raddr", 32'(bus.addr), 32'(e_addr));
      if (e_done) begin
        check("pc_out",   32'(bus.pc_out),   32'(m_pc));
        check("p_out",    32'(bus.p_out),    32'(m_p));
        check("data_out", 32'(bus.data_out), 32'(m_data));
      end
    end
  end

  task automatic set_idle_exp();
    e_busy = 1'b0; e_done = 1'b0; e_we = 1'b0; e_re = 1'b0;
    e_fault = 1'b0; e_sel = 2'b00; e_addr = '0; e_wdata = '0;
  endtask

  task automatic load_sp(input logic [7:0] v);
    @(posedge clk); #1;
    bus.start = 1'b0; sp_ld = 1'b1; sp_ld_val = v; msp = v;
    set_idle_exp(); cmp_en = 1'b1;
    @(posedge clk); #1;
    sp_ld = 1'b0;
  endtask

  // mode: 0 no stall, 1 random stalls, 2 two stall cycles before byte stall_k.
  // abort_after > 0 asserts reset once that many bytes have transferred.
  task automatic run_op(input logic [2:0] op, input logic [15:0] pc, input logic [7:0] p,
                        input logic [7:0] d, input int mode, input int stall_k,
                        input int abort_after);
    logic [7:0] bytes [3];
    logic [7:0] pulled [3];
    int n, k, cyc, run_stall, stalls_left;
    bit stall, first_seen;
    n = int'(op) / 2 + 1;
    bytes[0] = d; bytes[1] = 8'h00; bytes[2] = 8'h00;
    pulled[0] = 8'h00; pulled[1] = 8'h00; pulled[2] = 8'h00;
    if (op == 3'd2 || op == 3'd4) begin
      bytes[0] = pc[15:8];
      bytes[1] = pc[7:0];
      bytes[2] = p;
    end
    first_seen = 1'b0; fault_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.pc_in = pc; bus.p_in = p; bus.data_in = d;
    bus.rdy = 1'($urandom);
    set_idle_exp(); cmp_en = 1'b1;
    cyc = 0; k = 0; run_stall = 0;
    stalls_left = (mode == 2) ? 2 : 0;
    while (k < n) begin
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && k == abort_after) begin
        bus.rdy = 1'b0; bus.start = 1'b0; cmp_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_we",       32'(bus.we),       32'd0);
        check("rst_re",       32'(bus.re),       32'd0);
        check("rst_sp_sel",   32'(bus.sp_sel),   32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_addr",     32'(bus.addr),     32'd0);
        check("rst_pc_out",   32'(bus.pc_out),   32'd0);
        check("rst_p_out",    32'(bus.p_out),    32'd0);
        check("rst_data_out", 32'(bus.data_out), 32'd0);
        m_pc = '0; m_p = '0; m_data = '0;
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      bus.start = 1'($urandom_range(0, 1));
      bus.op = 3'($urandom_range(0, 7));
      bus.pc_in = 16'($urandom); bus.p_in = 8'($urandom); bus.data_in = 8'($urandom);
      stall = 1'b0;
      if (mode == 1 && run_stall < 3) stall = ($urandom_range(0, 3) == 0);
      if (mode == 2 && k == stall_k && stalls_left > 0) begin
        stall = 1'b1; stalls_left--;
      end
      run_stall = stall ? run_stall + 1 : 0;
      bus.rdy = !stall;
      set_idle_exp(); e_busy = 1'b1;
      if (!stall) begin
        if (!op[0]) begin
          e_we = 1'b1; e_sel = 2'b10; e_addr = {8'h01, msp}; e_wdata = bytes[k];
          e_fault = (msp == 8'h00);
          mmem[msp] = bytes[k];
          msp = msp - 8'd1;
        end else begin
          msp = msp + 8'd1;
          e_re = 1'b1; e_sel = 2'b01; e_addr = {8'h01, msp};
          e_fault = (msp == 8'h00);
          pulled[k] = mmem[msp];
        end
        k++;
      end
      #3;
      if (!stall && !first_seen) begin
        first_addr = bus.addr; first_wdata = bus.wdata; first_sel = bus.sp_sel;
        first_seen = 1'b1;
      end
      if (bus.fault) fault_cnt++;
    end
    @(posedge clk); #1;
    cyc++;
    bus.start = 1'($urandom_range(0, 1)); bus.op = 3'($urandom_range(0, 7));
    bus.rdy = 1'($urandom);
    set_idle_exp(); e_busy = 1'b1; e_done = 1'b1;
    case (op)
      3'd1: m_data = pulled[0];
      3'd3: m_pc = {pulled[1], pulled[0]};
      3'd5: begin m_p = pulled[0]; m_pc = {pulled[2], pulled[1]}; end
      default: ;
    endcase
    last_lat = cyc;
  endtask

  task automatic idle_cycle(input logic [2:0] op, input logic st);
    @(posedge clk); #1;
    bus.start = st; bus.op = op; bus.rdy = 1'($urandom);
    set_idle_exp(); cmp_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.pc_in = '0; bus.p_in = '0; bus.data_in = '0;
    bus.rdy = 1'b0;
    sp_ld = 1'b0; sp_ld_val = '0; mem_clr = 1'b1; cmp_en = 1'b0;
    msp = '0; m_pc = '0; m_p = '0; m_data = '0;
    for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
    set_idle_exp();
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   32'(bus.busy),   32'd0);
    check("reset_done",   32'(bus.done),   32'd0);
    check("reset_sp_sel", 32'(bus.sp_sel), 32'd0);
    check("reset_addr",   32'(bus.addr),   32'd0);
    check("reset_wdata",  32'(bus.wdata),  32'd0);
    check("reset_pc_out", 32'(bus.pc_out), 32'd0);
    mem_clr = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // PUSH1 A5 from FF
    load_sp(8'hFF);
    run_op(3'd0, 16'h0000, 8'h00, 8'hA5, 0, 0, 0);
    check("push1_addr",  32'(first_addr),  32'h01FF);
    check("push1_wdata", 32'(first_wdata), 32'hA5);
    check("push1_sel",   32'(first_sel),   32'd2);
    check("push1_lat",   32'(last_lat),    32'd2);

    // JSR 1234 then RTS
    load_sp(8'hFF);
    run_op(3'd2, 16'h1234, 8'h00, 8'h00, 0, 0, 0);
    run_op(3'd3, 16'h0000, 8'h00, 8'h00, 0, 0, 0);
    check("rts_first_addr", 32'(first_addr), 32'h01FE);
    check("rts_pc",         32'(bus.pc_out), 32'h1234);
    check("rts_sp",         32'(sp_reg),     32'hFF);
    check("jsr_mem_ff",     32'(mem[8'hFF]), 32'h12);
    check("jsr_mem_fe",     32'(mem[8'hFE]), 32'h34);

    // INT C000/24 then RTI with two stall cycles mid-sequence
    load_sp(8'hFF);
    run_op(3'd4, 16'hC000, 8'h24, 8'h00, 0, 0, 0);
    run_op(3'd5, 16'h0000, 8'h00, 8'h00, 2, 1, 0);
    check("rti_lat",  32'(last_lat),    32'd6);
    check("rti_p",    32'(bus.p_out),   32'h24);
    check("rti_pc",   32'(bus.pc_out),  32'hC000);
    check("rti_sp",   32'(sp_reg),      32'hFF);

    // Boundary: push at 00, pull with register at FF
    load_sp(8'h00);
    run_op(3'd0, 16'h0000, 8'h00, 8'h5A, 0, 0, 0);
    check("ovf_addr",  32'(first_addr), 32'h0100);
    check("ovf_fault", 32'(fault_cnt),  32'd1);
    check("ovf_sp",    32'(sp_reg),     32'hFF);
    run_op(3'd1, 16'h0000, 8'h00, 8'h00, 0, 0, 0);
    check("unf_addr",  32'(first_addr),    32'h0100);
    check("unf_fault", 32'(fault_cnt),     32'd1);
    check("unf_data",  32'(bus.data_out),  32'h5A);

    // Reserved ops are ignored
    idle_cycle(3'd6, 1'b1);
    idle_cycle(3'd7, 1'b1);
    idle_cycle(3'd0, 1'b0);
    idle_cycle(3'd0, 1'b0);

    // Reset mid-INT after the first byte, then a clean PUSH1/PULL1
    load_sp(8'hFF);
    run_op(3'd4, 16'hBEEF, 8'h81, 8'h00, 0, 0, 1);
    check("abort_sp",  32'(sp_reg),     32'hFE);
    check("abort_mem", 32'(mem[8'hFF]), 32'hBE);
    run_op(3'd0, 16'h0000, 8'h00, 8'h3C, 0, 0, 0);
    check("post_rst_addr", 32'(first_addr),   32'h01FE);
    check("post_rst_lat",  32'(last_lat),     32'd2);
    check("post_rst_data", 32'(bus.data_out), 32'h00);
    run_op(3'd1, 16'h0000, 8'h00, 8'h00, 0, 0, 0);
    check("post_rst_pull", 32'(bus.data_out), 32'h3C);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 7) == 0) load_sp(8'($urandom));
      if ($urandom_range(0, 15) == 0) idle_cycle(3'($urandom_range(6, 7)), 1'b1);
      run_op(3'($urandom_range(0, 5)), 16'($urandom), 8'($urandom), 8'($urandom), 1, 0, 0);
    end

    idle_cycle(3'd0, 1'b0);
    idle_cycle(3'd0, 1'b0);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Multi-byte stack access engine for the 6502 core: runs the byte sequences for push/pull, JSR/RTS and interrupt/RTI stack traffic on page $01. It is the consumer side of the stack pointer register. It drives that register's inc/dec select and forms stack addresses from its `sp` output. It also drives the memory bus for each stack byte and hands assembled PC/P/data back to the control unit.

## Interface
Parameters:
- `STACK_PAGE`, 8'h01, high address byte for all stack accesses

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request pulse; accepted only when `busy`=0
- `op`  in  3  000 PUSH1, 001 PULL1, 010 JSR (push PCH,PCL), 011 RTS (pull PCL,PCH), 100 INT (push PCH,PCL,P), 101 RTI (pull P,PCL,PCH); 110/111 reserved
- `pc_in`  in  16  PC value to push (JSR/INT), sampled at start
- `p_in`  in  8  status to push (INT), sampled at start
- `data_in`  in  8  byte to push (PUSH1), sampled at start
- `rdy`  in  1  bus ready; 0 stalls the current byte
- `sp`  in  8  stack pointer register output (already +1 when `sp_sel`=01)
- `sp_sel`  out  2  to stack pointer: 00 hold, 01 increment, 10 decrement
- `addr`  out  16  memory address
- `wdata`  out  8  write data
- `we`  out  1  write strobe
- `re`  out  1  read strobe
- `rdata`  in  8  read data, valid combinationally in the `re` cycle
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse
- `pc_out`  out  16  PC assembled by RTS/RTI
- `p_out`  out  8  status pulled by RTI
- `data_out`  out  8  byte pulled by PULL1
- `fault`  out  1  one-cycle pulse on stack overflow/underflow access

## Operation
- FSM states: IDLE, XFER, DONE. A 2-bit byte index runs 0..N-1, with N=1/1/2/2/3/3 per `op`.
- IDLE: `start`=1 with a valid `op` captures `op`, `pc_in`, `p_in` and `data_in`, clears the index and moves to XFER. A reserved `op` is ignored and the FSM stays in IDLE.
- XFER, `rdy`=0: `we`=`re`=0, `sp_sel`=00, index unchanged, `addr` don't-care.
- XFER push byte, `rdy`=1: `addr`={STACK_PAGE,`sp`}, `wdata` is the next byte in push order, `we`=1, `sp_sel`=10 (post-decrement).
- XFER pull byte, `rdy`=1: `sp_sel`=01, `addr`={STACK_PAGE,`sp`} (pre-incremented value), `re`=1. `rdata` is latched into the target register at the clock edge.
- After the last byte completes, the FSM goes to DONE. DONE asserts `done`=1 for one cycle, then returns to IDLE.
- Byte order: JSR writes PCH then PCL. INT writes PCH, PCL, P. RTS reads PCL then PCH. RTI reads P, PCL, PCH.
- The PC is not adjusted in either direction; the control unit handles the +1/+2 fixups.
- Result registers hold their value until overwritten by a later pull of the same kind.
- Fault: a push issued with `sp`=8'h00, or a pull issued with `sp`=8'h00 (the register wrapped from FF), still performs the access and pulses `fault` in that access cycle. The sequence continues.
- `start` while `busy`=1 is ignored.
- `sp_load` is never driven by this block.

## Timing
- Reset (asynchronous, any state): FSM goes to IDLE. `busy`, `done`, `fault`, `we`, `re` go to 0 immediately. `sp_sel`=00, `addr`=0, `wdata`=0, `pc_out`=0, `p_out`=0, `data_out`=0. An aborted sequence leaves a partial stack update with no `done`.
- With `start` at cycle 0, `busy`=1 from cycle 1 through the DONE cycle.
- With no stalls, bytes are transferred in cycles 1..N and `done` is high in cycle N+1. Each `rdy`=0 cycle adds one cycle.
- Outputs `pc_out`/`p_out`/`data_out` are valid in the `done` cycle.
- A new `start` is accepted at the earliest in cycle N+2.
- `sp_sel` is nonzero only in active transfer cycles; there is exactly one inc/dec per byte.
- `we`, `re` and `sp_sel` are combinational from state, index and `rdy`.

## Test plan
- PUSH1 `data_in`=8'hA5, `sp`=8'hFF, no stall -> cycle 1: `addr`=16'h01FF, `we`=1, `wdata`=A5, `sp_sel`=10. Cycle 2: `done`=1.
- JSR `pc_in`=16'h1234 from SP FF, then RTS -> writes 12 @01FF and 34 @01FE. RTS reads @01FE then @01FF, giving `pc_out`=16'h1234 and SP back at FF.
- INT `pc_in`=16'hC000, `p_in`=8'h24, then RTI, with `rdy`=0 for 2 cycles mid-sequence -> stall cycles have no strobes and no SP change. RTI returns `p_out`=24, `pc_out`=C000, and `done` is 2 cycles later than the unstalled case.
- PUSH1 at `sp`=8'h00 -> write @0100 with `fault` pulse. PULL1 at SP register FF (`sp` reads 00) -> read @0100 with `fault` pulse.
- Cases with no effect -> reserved `op`=110, or `start` while busy: no strobes and no `done`.
- Reset mid-INT after the first byte -> `busy`/`we` drop asynchronously. Outputs return to 0 and the next PUSH1 starts cleanly.
